// File: rtl/pwm_value_filter.sv
// pwm_value_filter: clamps, averages and scales one RC channel pulse width to an 8-bit command, with signal-loss failsafe.
//   sys_clk, reset (sync, active-high)
//   us_tick                 one-cycle strobe per microsecond
//   pwm_pulse_length_us     latest measured pulse width (us), qualified by pulse_valid
//   channel_value           filtered, scaled command (0..255), FAILSAFE_VALUE while lost
//   value_valid             one-cycle strobe, 3 cycles after pulse_valid
//   signal_lost             high after TIMEOUT_US us without a pulse
//   Optional macro PWM_CENTER_DEADBAND_EN snaps averages within DEADBAND_US of centre to 500.
module pwm_value_filter #(
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT_US = 25000,
  parameter logic [7:0] FAILSAFE_VALUE = 8'd0,
  parameter int DEADBAND_US = 10
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        us_tick,
  input  logic [10:0] pwm_pulse_length_us,
  input  logic        pulse_valid,
  output logic [7:0]  channel_value,
  output logic        value_valid,
  output logic        signal_lost
);
  localparam int N = 1 << AVG_LOG2;
  localparam int PW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int SW = 10 + AVG_LOG2;
  logic [15:0] tmo_cnt;
  logic loss;
  logic s1_valid, s2_valid, hist_full;
  logic [9:0] s1_off, s2_avg, off_c, avg_c, avg_f;
  logic [9:0] buf_q [N];
  logic [PW-1:0] wr;
  logic [SW-1:0] sum, sum_c;
  logic [8:0] scaled;
  logic [7:0] cv_c;
  // A pulse arriving with the terminal tick keeps the link alive.
  assign loss = us_tick && !pulse_valid && !signal_lost && tmo_cnt == 16'(TIMEOUT_US - 1);
  assign off_c = pwm_pulse_length_us < 11'd1000 ? 10'd0 :
                 pwm_pulse_length_us > 11'd2000 ? 10'd1000 : 10'(pwm_pulse_length_us - 11'd1000);
  // Empty history is preloaded with the first sample so the output does not ramp up from zero.
  assign sum_c = hist_full ? sum - SW'(buf_q[wr]) + SW'(s1_off) : SW'(s1_off) << AVG_LOG2;
  assign avg_c = 10'(sum_c >> AVG_LOG2);
`ifdef PWM_CENTER_DEADBAND_EN
  assign avg_f = (avg_c >= 10'(500 - DEADBAND_US) && avg_c <= 10'(500 + DEADBAND_US)) ? 10'd500 : avg_c;
`else
  assign avg_f = avg_c;
`endif
  // 1045/4096 maps 0..1000 onto 0..255.
  assign scaled = 9'((21'(s2_avg) * 21'd1045) >> 12);
  assign cv_c = scaled > 9'd255 ? 8'd255 : scaled[7:0];
  always_ff @(posedge sys_clk) begin
    if (s1_valid) begin
      if (!hist_full) for (int i = 0; i < N; i++) buf_q[i] <= s1_off;
      else buf_q[wr] <= s1_off;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      s1_valid <= 1'b0;
      s1_off <= '0;
      s2_valid <= 1'b0;
      s2_avg <= '0;
      sum <= '0;
      wr <= '0;
      hist_full <= 1'b0;
      channel_value <= FAILSAFE_VALUE;
      value_valid <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      tmo_cnt <= (pulse_valid || loss) ? 16'd0 : (us_tick && !signal_lost) ? tmo_cnt + 16'd1 : tmo_cnt;
      s1_valid <= pulse_valid;
      s1_off <= pulse_valid ? off_c : s1_off;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_avg <= avg_f;
        sum <= sum_c;
        hist_full <= 1'b1;
        if (hist_full) wr <= (wr == PW'(N - 1)) ? '0 : wr + 1'b1;
      end
      if (loss) hist_full <= 1'b0;
      value_valid <= s2_valid && !loss;
      channel_value <= loss ? FAILSAFE_VALUE : s2_valid ? cv_c : channel_value;
      signal_lost <= loss ? 1'b1 : s2_valid ? 1'b0 : signal_lost;
    end
  end
endmodule
